sequential_divider: RTL and testbench
=====================================

# sequential_divider

Multi-cycle unsigned integer divider for the ALU datapath, the inverse operation to the combinational multiply path. One restoring shift-subtract step per clock, using a WIDTH+1-bit subtract built on the adder_substractor pattern (select = 1, borrow taken from the carry-out). It accepts operands on a start pulse, reports busy during iteration, and pulses done with a registered quotient and remainder. The ALU control FSM stalls on busy_o.

## Interface
- WIDTH, default 8: operand and result width in bits; must be 2 or more.
- clk_i  in  1  clock; all logic updates on the rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  request; sampled each rising edge.
- bus_a_i  in  WIDTH  dividend, unsigned.
- bus_b_i  in  WIDTH  divisor, unsigned.
- busy_o  out  1  high while iterating.
- done_o  out  1  one-cycle pulse when results become valid.
- quotient_o  out  WIDTH  registered quotient.
- remainder_o  out  WIDTH  registered remainder.
- flag_z_o  out  1  divide-by-zero flag for the last completed operation.

## Operation
- FSM states:
  - IDLE: start_i=1 with bus_b_i≠0 → RUN. start_i=1 with bus_b_i=0 → DONE.
  - RUN: stays in RUN until the iteration counter reaches WIDTH, then → DONE.
  - DONE: start_i=1 is accepted exactly as in IDLE. Otherwise → IDLE.
- Accept: an accept occurs when start_i=1 at an edge in IDLE or DONE.
  - On accept, latch the dividend into the shift register, the divisor into the divisor register, clear the partial remainder (WIDTH+1 bits), and set count=0.
  - Operand inputs are ignored after the accept.
- start_i is ignored while in RUN. There is no queueing.
- RUN step, once per cycle:
  - r' = {r[WIDTH-1:0], dividend MSB}; shift the dividend left by one.
  - Compute d = r' − {0, divisor}.
  - If no borrow (d[WIDTH]=0): r ← d and shift in quotient bit 1.
  - Otherwise: r ← r' and shift in quotient bit 0.
  - count increments.
- Entering DONE from RUN: quotient_o ← quotient register, remainder_o ← r[WIDTH-1:0], flag_z_o ← 0.
- Entering DONE on divide-by-zero: quotient_o ← all ones, remainder_o ← dividend, flag_z_o ← 1.
- Result outputs change only when entering DONE or on reset. They hold between operations.
- Invariant for a nonzero divisor: dividend = quotient·divisor + remainder, and remainder < divisor.
- Reset: state IDLE, all internal registers 0.
  - busy_o=0, done_o=0, quotient_o=0, remainder_o=0, flag_z_o=0.
  - Reset in RUN or DONE aborts the operation: no done_o pulse and no result update.

## Timing
- Edges are numbered with the accept at edge k.
- Normal operation:
  - busy_o=1 after edges k through k+WIDTH−1, i.e. exactly WIDTH cycles.
  - done_o=1 after edge k+WIDTH, for exactly one cycle.
  - Results are valid in the same cycle as done_o.
- Divide-by-zero: busy_o stays 0, and done_o=1 after edge k+1.
- busy_o and done_o are never high together.
- All outputs are registered: no combinational path from inputs to outputs.
- Back-to-back operation: start_i=1 during the done_o cycle is accepted.
  - busy_o rises after that edge.
  - The previous results hold until the new operation reaches DONE.
- Throughput: one division per WIDTH+1 cycles.

## Test plan
- WIDTH=8, reset: hold rst_n_i=0 for 2 cycles → all outputs 0. After release with no start, outputs stay 0.
- 100 ÷ 7 → busy_o high for 8 cycles, then a single done_o pulse with quotient_o=14, remainder_o=2, flag_z_o=0.
- 255 ÷ 1, then immediately 5 ÷ 9 (start_i held high in the done cycle):
  - first done_o: q=255, r=0;
  - second done_o 9 cycles later: q=0, r=5;
  - no idle cycle between the two operations.
- 37 ÷ 0 → done_o one edge after accept, busy_o never high, q=255, r=37, flag_z_o=1. A following 9 ÷ 3 clears flag_z_o, with q=3, r=0.
- Mid-run disturbance:
  - start 200 ÷ 13;
  - change the operands and pulse start_i during RUN → ignored, result q=15, r=5;
  - repeat the run and assert rst_n_i=0 at iteration 4 → no done_o, outputs 0, then returns to IDLE.
- Random sweep of 2000 operand pairs, including 0 and 255 → checker confirms a·… specifically a = q·b + r and r < b for every b≠0, and the exact done_o cycle count for each operation.

Source files
------------

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one shift-subtract step per clock,
// with registered quotient/remainder, busy/done handshake and divide-by-zero flag.
module sequential_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] bus_a_i,
  input  logic [WIDTH-1:0] bus_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             flag_z_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DZ   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             flag_z_q, flag_z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dvd;

  // One restoring step; the dividend register collects quotient bits at its LSB.
  assign r_shift  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign diff     = r_shift + ~{1'b0, dvs_q} + (WIDTH+1)'(1);
  assign step_rem = diff[WIDTH] ? r_shift : diff;
  assign step_dvd = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    remd_d   = remd_q;
    flag_z_d = flag_z_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          dvd_d   = bus_a_i;
          dvs_d   = bus_b_i;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (bus_b_i == '0) ? ST_DZ : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = ST_DONE;
          quot_d   = step_dvd;
          remd_d   = step_rem[WIDTH-1:0];
          flag_z_d = 1'b0;
        end
      end
      // Zero divisor: one holding cycle so done arrives one edge after accept.
      ST_DZ: begin
        state_d  = ST_DONE;
        quot_d   = '1;
        remd_d   = dvd_q;
        flag_z_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      remd_q   <= '0;
      flag_z_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      remd_q   <= remd_d;
      flag_z_q <= flag_z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = remd_q;
  assign flag_z_o    = flag_z_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (WIDTH=8): vector table, corner
// sequences and a randomized sweep against an arithmetic reference model.
module tb_sequential_divider;

  localparam int unsigned W = 8;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         start_i;
  logic [W-1:0] bus_a_i;
  logic [W-1:0] bus_b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         flag_z_o;

  sequential_divider #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .bus_a_i     (bus_a_i),
    .bus_b_i     (bus_b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .flag_z_o    (flag_z_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_cnt;
  int busy_cnt;
  int both_seen;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sample #1 after each rising edge; track latency, busy cycles, busy/done overlap.
  task automatic step();
    @(posedge clk_i);
    #1;
    lat_cnt++;
    if (busy_o) busy_cnt++;
    if (busy_o && done_o) both_seen = 1;
  endtask

  // Accept happens at the next edge; operands are scrambled right after it.
  task automatic start_op(input int a, input int b);
    @(negedge clk_i);
    start_i = 1'b1;
    bus_a_i = W'(a);
    bus_b_i = W'(b);
    @(posedge clk_i);
    #1;
    start_i   = 1'b0;
    bus_a_i   = W'($urandom);
    bus_b_i   = W'($urandom);
    lat_cnt   = 0;
    busy_cnt  = busy_o ? 1 : 0;
    both_seen = (busy_o && done_o) ? 1 : 0;
  endtask

  task automatic wait_done();
    while (!done_o && lat_cnt < 40) step();
  endtask

  task automatic check_result(input string nm, input int q, input int r, input int z,
                              input int lat);
    check({nm, ".lat"},  lat_cnt, lat);
    check({nm, ".done"}, int'(done_o), 1);
    check({nm, ".q"},    int'(quotient_o), q);
    check({nm, ".r"},    int'(remainder_o), r);
    check({nm, ".z"},    int'(flag_z_o), z);
    check({nm, ".busy"}, busy_cnt, (z != 0) ? 0 : W);
    check({nm, ".excl"}, both_seen, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int ea, eb, eq, er, ez, elat, gap, sel;
    int seen_done;
    int q_hold, r_hold;

    vecs[0] = '{100,   7,  14,  2, 0, 8};
    vecs[1] = '{255,   1, 255,  0, 0, 8};
    vecs[2] = '{  5,   9,   0,  5, 0, 8};
    vecs[3] = '{ 37,   0, 255, 37, 1, 1};
    vecs[4] = '{  9,   3,   3,  0, 0, 8};
    vecs[5] = '{  0,   5,   0,  0, 0, 8};
    vecs[6] = '{255, 255,   1,  0, 0, 8};
    vecs[7] = '{  0,   0, 255,  0, 1, 1};
    vecs[8] = '{  1, 255,   0,  1, 0, 8};
    vecs[9] = '{128,   2,  64,  0, 0, 8};

    rst_n_i = 1'b0;
    start_i = 1'b0;
    bus_a_i = '0;
    bus_b_i = '0;

    // Reset held for two cycles, then released with no start.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.busy", int'(busy_o), 0);
    check("rst.done", int'(done_o), 0);
    check("rst.q",    int'(quotient_o), 0);
    check("rst.r",    int'(remainder_o), 0);
    check("rst.z",    int'(flag_z_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("idle.busy", int'(busy_o), 0);
    check("idle.done", int'(done_o), 0);
    check("idle.q",    int'(quotient_o), 0);
    check("idle.r",    int'(remainder_o), 0);

    // Table-driven vectors (includes 37/0 followed by 9/3 clearing the flag).
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done();
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat);
      step();
      check($sformatf("vec%0d.pulse", i), int'(done_o), 0);
    end

    // Back-to-back: start held during the done cycle of 255/1.
    start_op(255, 1);
    wait_done();
    check_result("b2b1", 255, 0, 0, 8);
    start_op(5, 9);
    check("b2b.busy_rise", int'(busy_o), 1);
    check("b2b.hold_q",    int'(quotient_o), 255);
    wait_done();
    check_result("b2b2", 0, 5, 0, 8);

    // Start pulse with new operands during RUN is ignored.
    step();
    start_op(200, 13);
    repeat (3) step();
    @(negedge clk_i);
    start_i = 1'b1;
    bus_a_i = 8'd50;
    bus_b_i = 8'd3;
    step();
    start_i = 1'b0;
    wait_done();
    check_result("midrun", 15, 5, 0, 8);

    // Reset at iteration 4 aborts: no done, outputs cleared, back to idle.
    step();
    start_op(200, 13);
    repeat (4) step();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("abort.busy", int'(busy_o), 0);
    check("abort.q",    int'(quotient_o), 0);
    check("abort.r",    int'(remainder_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    seen_done = 0;
    repeat (12) begin
      step();
      if (done_o || busy_o) seen_done = 1;
    end
    check("abort.quiet", seen_done, 0);
    check("abort.q2",    int'(quotient_o), 0);
    start_op(9, 3);
    wait_done();
    check_result("after_abort", 3, 0, 0, 8);

    // Random sweep against an arithmetic model.
    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(0, 9));
      ea  = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 9));
      eb  = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
      if (eb == 0) begin
        eq = 255; er = ea; ez = 1; elat = 1;
      end else begin
        eq = ea / eb; er = ea % eb; ez = 0; elat = W;
      end
      start_op(ea, eb);
      wait_done();
      check_result($sformatf("rnd%0d(%0d/%0d)", n, ea, eb), eq, er, ez, elat);
      if (eb != 0) begin
        check("rnd.identity", int'(quotient_o) * eb + int'(remainder_o), ea);
        check("rnd.rem_lt",   (int'(remainder_o) < eb) ? 1 : 0, 1);
      end
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        q_hold = int'(quotient_o);
        r_hold = int'(remainder_o);
        step();
        check("rnd.pulse", int'(done_o), 0);
        check("rnd.hold",  int'(quotient_o) * 256 + int'(remainder_o), q_hold * 256 + r_hold);
        repeat (gap - 1) step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
